// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
// Memory returns 16 bytes big-endian; loads take their bytes from the top of that line.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_FETCH,
      ARB_DATA
   } arb_state_e;

   localparam int unsigned StreakW = 4;

   // Right-justify and zero-extend the leading bytes of a big-endian line; size 3 acts as word.
   function automatic logic [31:0] be_load_extract(input logic [127:0] rdata,
                                                   input logic [1:0]   size);
      logic [31:0] res;
      case (size)
         MEM_BYTE: res = {24'b0, rdata[127:120]};
         MEM_HALF: res = {16'b0, rdata[127:112]};
         default:  res = rdata[127:96];
      endcase
      return res;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, load/store and memory-port signals of the unified memory arbiter.
// slave is the arbiter's view; master is the view of whoever drives requesters and memory.
interface unified_mem_arbiter_if;

   logic         if_req;
   logic [31:0]  if_addr;
   logic         if_flush;
   logic [127:0] if_rdata;
   logic         if_ack;

   logic         d_req;
   logic         d_we;
   logic [1:0]   d_size;
   logic [31:0]  d_addr;
   logic [31:0]  d_wdata;
   logic [31:0]  d_rdata;
   logic         d_ack;

   logic         mem_req;
   logic         mem_we;
   logic [1:0]   mem_size;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ack;

   modport slave (
      input  if_req, if_addr, if_flush, d_req, d_we, d_size, d_addr, d_wdata,
             mem_rdata, mem_ack,
      output if_rdata, if_ack, d_rdata, d_ack,
             mem_req, mem_we, mem_size, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush, d_req, d_we, d_size, d_addr, d_wdata,
             mem_rdata, mem_ack,
      input  if_rdata, if_ack, d_rdata, d_ack,
             mem_req, mem_we, mem_size, mem_addr, mem_wdata
   );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares the unified memory port between instruction fetch and load/store, one transaction
// at a time. Data wins ties unless fetch has waited FETCH_STARVE_MAX data grants.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int unsigned FETCH_STARVE_MAX = 4
) (
   input logic                  clk,
   input logic                  rst,
   unified_mem_arbiter_if.slave bus_io
);

   localparam logic [StreakW-1:0] StreakMax = StreakW'(FETCH_STARVE_MAX);

   arb_state_e         state_q, state_d;
   logic [StreakW-1:0] streak_q, streak_d;
   logic               drop_q, drop_d;
   logic [31:0]        addr_q, addr_d;
   logic               we_q, we_d;
   logic [1:0]         size_q, size_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [127:0]       if_rdata_q, if_rdata_d;
   logic [31:0]        d_rdata_q, d_rdata_d;

   logic        fetch_elig, grant_data, grant_fetch;
   logic        fetch_done, data_done, if_ack;
   logic [31:0] load_data;

   assign fetch_elig  = bus_io.if_req & ~bus_io.if_flush;
   assign grant_data  = bus_io.d_req & (~fetch_elig | (streak_q < StreakMax));
   assign grant_fetch = fetch_elig & ~grant_data;

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      drop_d   = drop_q;
      addr_d   = addr_q;
      we_d     = we_q;
      size_d   = size_q;
      wdata_d  = wdata_q;
      case (state_q)
         ARB_IDLE: begin
            drop_d = 1'b0;
            if (grant_data) begin
               state_d = ARB_DATA;
               addr_d  = bus_io.d_addr;
               we_d    = bus_io.d_we;
               size_d  = (bus_io.d_size == 2'd3) ? MEM_WORD : bus_io.d_size;
               wdata_d = bus_io.d_wdata;
               // Streak counts only data grants that made an eligible fetch wait.
               if (!fetch_elig) begin
                  streak_d = '0;
               end else if (streak_q != '1) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (grant_fetch) begin
               state_d  = ARB_FETCH;
               addr_d   = bus_io.if_addr;
               we_d     = 1'b0;
               size_d   = MEM_WORD;
               wdata_d  = '0;
               streak_d = '0;
            end
         end
         ARB_FETCH: begin
            drop_d = drop_q | bus_io.if_flush;
            if (bus_io.mem_ack) begin
               state_d = ARB_IDLE;
               drop_d  = 1'b0;
            end
         end
         ARB_DATA: begin
            if (bus_io.mem_ack) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Completion is combinational from mem_ack; a flush in the ack cycle still suppresses it.
   assign fetch_done = (state_q == ARB_FETCH) & bus_io.mem_ack;
   assign data_done  = (state_q == ARB_DATA) & bus_io.mem_ack;
   assign if_ack     = fetch_done & ~drop_q & ~bus_io.if_flush;
   assign load_data  = we_q ? 32'd0 : be_load_extract(bus_io.mem_rdata, size_q);
   assign if_rdata_d = if_ack ? bus_io.mem_rdata : if_rdata_q;
   assign d_rdata_d  = data_done ? load_data : d_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         streak_q   <= '0;
         drop_q     <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         size_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         drop_q     <= drop_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign bus_io.mem_req   = (state_q != ARB_IDLE);
   assign bus_io.mem_we    = we_q;
   assign bus_io.mem_size  = size_q;
   assign bus_io.mem_addr  = addr_q;
   assign bus_io.mem_wdata = wdata_q;
   assign bus_io.if_ack    = if_ack;
   assign bus_io.if_rdata  = if_rdata_d;
   assign bus_io.d_ack     = data_done;
   assign bus_io.d_rdata   = d_rdata_d;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, loads, store, contention order, flush and reset.
// Inputs change at negedge+3; a memory responder acks a configurable number of cycles after mem_req.
module tb_unified_mem_arbiter;
   import unified_mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   unified_mem_arbiter_if bus ();

   unified_mem_arbiter #(.FETCH_STARVE_MAX(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory responder: ack lat cycles after mem_req is first seen (lat=0 -> same cycle).
   int lat    = 1;
   bit mem_en = 1'b1;
   int wcnt   = 0;
   initial forever begin
      @(negedge clk);
      if (mem_en) begin
         bus.mem_ack = 1'b0;
         if (rst || !bus.mem_req) begin
            wcnt = 0;
         end else if (wcnt >= lat) begin
            bus.mem_ack = 1'b1;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end
   end

   // Monitor: counts requester acks, records grant order and the latched memory fields.
   int           if_cnt = 0, d_cnt = 0, both_cnt = 0;
   logic [127:0] if_seen = '0;
   logic [31:0]  d_seen = '0;
   bit           order_q[$];
   logic [31:0]  m_addr = '0, m_wdata = '0;
   logic         m_we = 1'b0;
   logic [1:0]   m_size = '0;
   initial forever begin
      @(negedge clk);
      #2;
      if (bus.mem_req) begin
         m_addr  = bus.mem_addr;
         m_we    = bus.mem_we;
         m_size  = bus.mem_size;
         m_wdata = bus.mem_wdata;
      end
      if (bus.if_ack && bus.d_ack) both_cnt++;
      if (bus.if_ack) begin
         if_cnt++;
         if_seen = bus.if_rdata;
         order_q.push_back(1'b1);
      end
      if (bus.d_ack) begin
         d_cnt++;
         d_seen = bus.d_rdata;
         order_q.push_back(1'b0);
      end
   end

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_acks(input string tag, input int n_if, input int n_d, input int max_cyc);
      int c = 0;
      while ((if_cnt < n_if || d_cnt < n_d) && c < max_cyc) begin
         tick();
         c++;
      end
      check_eq({tag, "_ack_seen"}, (if_cnt >= n_if && d_cnt >= n_d), 1'b1);
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int c = 0;
      while (bus.mem_req && c < max_cyc) begin
         tick();
         c++;
      end
      check_eq({tag, "_idle"}, bus.mem_req, 1'b0);
   endtask

   task automatic do_data(input string tag, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
      int target;
      target      = d_cnt + 1;
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_size  = size;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      tick();
      // Scramble inputs after grant; the latched transaction must not change.
      bus.d_req   = 1'b0;
      bus.d_we    = ~we;
      bus.d_size  = 2'd0;
      bus.d_addr  = 32'hFFFF_FFFF;
      bus.d_wdata = 32'h5A5A_5A5A;
      wait_acks(tag, 0, target, 10);
      tick();
   endtask

   localparam logic [127:0] FetchData = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
   localparam logic [127:0] LoadLine  = 128'hA1B2_C3D4_0102_0304_0506_0708_090A_0B0C;

   int  snap;
   bit  exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.if_flush  = 1'b0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_size    = '0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      repeat (2) tick();

      check_eq("rst_mem_req", bus.mem_req, 1'b0);
      check_eq("rst_if_ack", bus.if_ack, 1'b0);
      check_eq("rst_d_ack", bus.d_ack, 1'b0);
      check_eq("rst_if_rdata", bus.if_rdata, '0);
      check_eq("rst_d_rdata", bus.d_rdata, '0);
      check_eq("rst_mem_addr", bus.mem_addr, '0);
      check_eq("rst_state", dut.state_q, ARB_IDLE);
      check_eq("rst_streak", dut.streak_q, 4'd0);
      rst = 1'b0;
      tick();

      // Fetch only, 1-cycle memory latency.
      lat           = 1;
      bus.mem_rdata = FetchData;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h100;
      tick();
      check_eq("fetch_mem_req", bus.mem_req, 1'b1);
      check_eq("fetch_mem_addr", bus.mem_addr, 32'h100);
      check_eq("fetch_mem_size", bus.mem_size, 2'd2);
      check_eq("fetch_mem_we", bus.mem_we, 1'b0);
      bus.if_req  = 1'b0;
      bus.if_addr = 32'hDEAD_BEEF;
      wait_acks("fetch", 1, 0, 10);
      tick();
      check_eq("fetch_rdata", if_seen, FetchData);
      check_eq("fetch_if_cnt", if_cnt, 1);
      check_eq("fetch_no_d_ack", d_cnt, 0);
      check_eq("fetch_rdata_hold", bus.if_rdata, FetchData);
      check_eq("fetch_ack_low", bus.if_ack, 1'b0);

      // Loads of each size from the top of the line.
      bus.mem_rdata = LoadLine;
      do_data("ld_byte", 1'b0, 2'd0, 32'h203, 32'h0);
      check_eq("ld_byte_addr", m_addr, 32'h203);
      check_eq("ld_byte_size", m_size, 2'd0);
      check_eq("ld_byte_data", d_seen, 32'h0000_00A1);
      do_data("ld_half", 1'b0, 2'd1, 32'h203, 32'h0);
      check_eq("ld_half_data", d_seen, 32'h0000_A1B2);
      do_data("ld_word", 1'b0, 2'd2, 32'h203, 32'h0);
      check_eq("ld_word_data", d_seen, 32'hA1B2_C3D4);
      do_data("ld_sz3", 1'b0, 2'd3, 32'h204, 32'h0);
      check_eq("ld_sz3_size", m_size, 2'd2);
      check_eq("ld_sz3_data", d_seen, 32'hA1B2_C3D4);
      check_eq("ld_d_rdata_hold", bus.d_rdata, 32'hA1B2_C3D4);

      // Store half.
      snap = d_cnt;
      do_data("st_half", 1'b1, 2'd1, 32'h40, 32'h0000_BEEF);
      check_eq("st_we", m_we, 1'b1);
      check_eq("st_size", m_size, 2'd1);
      check_eq("st_addr", m_addr, 32'h40);
      check_eq("st_wdata", m_wdata, 32'h0000_BEEF);
      check_eq("st_rdata_zero", d_seen, 32'h0);
      repeat (3) tick();
      check_eq("st_single_ack", d_cnt, snap + 1);

      // Contention with same-cycle ack: D,D,D,D,F repeated.
      lat = 0;
      order_q.delete();
      both_cnt    = 0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_size  = 2'd2;
      bus.d_addr  = 32'h80;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h400;
      for (int c = 0; c < 60 && order_q.size() < 10; c++) tick();
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      repeat (4) tick();
      check_eq("cont_count", order_q.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < order_q.size()) check_eq($sformatf("cont_grant%0d", i), order_q[i], exp_order[i]);
      end
      check_eq("cont_no_dual_ack", both_cnt, 0);

      // Flush while a fetch is in flight.
      lat         = 3;
      snap        = if_cnt;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h300;
      tick();
      check_eq("flush_granted", bus.mem_req, 1'b1);
      bus.if_req   = 1'b0;
      bus.if_flush = 1'b1;
      tick();
      bus.if_flush = 1'b0;
      wait_idle("flush", 10);
      tick();
      check_eq("flush_no_if_ack", if_cnt, snap);
      check_eq("flush_state", dut.state_q, ARB_IDLE);
      check_eq("flush_drop_clear", dut.drop_q, 1'b0);

      // Request and flush together in IDLE: nothing granted.
      bus.if_req   = 1'b1;
      bus.if_flush = 1'b1;
      tick();
      check_eq("reqflush_no_grant", bus.mem_req, 1'b0);
      bus.if_req   = 1'b0;
      bus.if_flush = 1'b0;
      tick();

      // Reset in the middle of a data transaction with a waiting fetch.
      lat        = 10;
      snap       = d_cnt;
      bus.d_req  = 1'b1;
      bus.d_size = 2'd2;
      bus.d_addr = 32'h500;
      bus.if_req = 1'b1;
      tick();
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      check_eq("rstmid_busy", bus.mem_req, 1'b1);
      check_eq("rstmid_streak_pre", dut.streak_q, 4'd1);
      tick();
      mem_en      = 1'b0;
      bus.mem_ack = 1'b0;
      rst         = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstmid_mem_req", bus.mem_req, 1'b0);
      check_eq("rstmid_state", dut.state_q, ARB_IDLE);
      check_eq("rstmid_streak", dut.streak_q, 4'd0);
      bus.mem_ack = 1'b1;
      #1;
      check_eq("late_ack_no_d_ack", bus.d_ack, 1'b0);
      check_eq("late_ack_no_if_ack", bus.if_ack, 1'b0);
      tick();
      bus.mem_ack = 1'b0;
      tick();
      check_eq("late_ack_idle", bus.mem_req, 1'b0);
      check_eq("late_ack_d_cnt", d_cnt, snap);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single unified memory port between two requesters: the instruction fetch unit (16-byte big-endian wide reads) and the load/store data port (byte/half/word reads and writes).
- Keeps at most one transaction outstanding and latches address, command and data at grant.
- Data has priority, with a starvation guard for fetch.
- Discards stale fetch responses when fetch is flushed on a taken branch.

Parameters:
- FETCH_STARVE_MAX, 4: consecutive data grants allowed while fetch waits before fetch is forced through (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_flush  in  1  branch flush; cancels pending or in-flight fetch
- if_rdata  out  128  16 bytes from if_addr; byte at if_addr is in [127:120]
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request
- d_we  in  1  1 = store
- d_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
- d_addr  in  32  data byte address, any alignment
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  load data, right-justified, zero-extended
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_size  out  2  access size (fetch always issues 2)
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_rdata  in  128  16 bytes starting at mem_addr, big-endian
- mem_ack  in  1  completion; may arrive in the same cycle mem_req first rises

Behaviour:
- Reset: synchronous, active-high, on rst; clock clk.
  - After reset: state IDLE, all outputs 0, streak counter 0, drop flag 0.
  - Reset mid-transaction abandons it. A late mem_ack seen in IDLE is ignored and produces no ack.
- States:
  - IDLE -> FETCH when fetch is granted.
  - IDLE -> DATA when data is granted.
  - FETCH/DATA -> IDLE on mem_ack.
  - No other transitions.
- Grant rules (evaluated in IDLE only):
  - Only d_req: grant data.
  - Only if_req with if_flush=0: grant fetch.
  - Both pending: grant data unless streak >= FETCH_STARVE_MAX, then grant fetch.
  - if_req with if_flush=1 in the same cycle: fetch is not eligible.
- At grant, register mem_addr, mem_we, mem_size and mem_wdata. mem_req rises the next cycle.
  - Fetch grant drives mem_we=0, mem_size=2, mem_wdata=0.
  - Requesters may change or drop their inputs after grant without affecting the transaction.
- Streak counter (4 bits):
  - Increments, saturating, on a data grant while if_req=1 and if_flush=0.
  - Clears on a fetch grant.
  - Clears on a data grant with no eligible fetch.
- While in FETCH or DATA, mem_req=1 and the latched fields stay stable until mem_ack.
- Completion (combinational from mem_ack):
  - FETCH: if_ack = mem_ack & !drop, and if_rdata = mem_rdata.
  - DATA: d_ack = mem_ack.
  - Loads take data from the top bytes of mem_rdata:
    - byte: {24'b0, [127:120]}
    - half: {16'b0, [127:112]}
    - word: [127:96]
  - Stores produce d_ack with d_rdata=0.
- Flush:
  - if_flush in FETCH (any cycle up to and including the mem_ack cycle) sets drop.
  - The mem transaction still completes but if_ack stays 0.
  - drop clears on return to IDLE.
  - if_flush has no effect on a DATA transaction.
- Outside the completion cycle: if_ack=0, d_ack=0, and if_rdata/d_rdata hold their last acked values (registered copies).
- Timing: minimum two cycles per transaction.
  - grant cycle -> mem_req cycle (mem_ack earliest here, requester ack the same cycle) -> IDLE.
  - Peak rate is one transaction every 2 cycles.

Decomposition:
- Add to neocore_pkg:
  - mem_size_e {MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2}
  - arb_state_e {ARB_IDLE, ARB_FETCH, ARB_DATA}
  - function be_load_extract(rdata128, size) returning 32 bits.
- No sub-module: the datapath is registers plus the extract function.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, memory acks 1 cycle after mem_req with rdata=0x0011..EEFF -> mem_addr=0x100, mem_size=2, one if_ack pulse carrying that rdata, d_ack never asserts.
- Load byte: d_size=0, d_addr=0x203, mem_rdata[127:96]=0xA1B2C3D4 -> d_rdata=0x000000A1. Repeat with half -> 0x0000A1B2, and word -> 0xA1B2C3D4.
- Store: d_we=1, d_size=1, d_wdata=0x0000BEEF, d_addr=0x40 -> mem_we=1, mem_size=1, mem_wdata=0x0000BEEF, single d_ack.
- Contention: d_req and if_req held high continuously, FETCH_STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; never two requester acks in one cycle.
- Flush in flight: fetch granted, if_flush pulsed before a 3-cycle-latency mem_ack -> no if_ack, state returns to IDLE. if_req+if_flush together in IDLE -> no grant.
- Reset mid-DATA: rst asserted while mem_req=1, then mem_ack arrives post-reset -> mem_req=0, no d_ack, state IDLE, streak=0.
